lb_alloc_ctrl: RTL

LB_ALLOC_CTRL -- requirements
Module: lb_alloc_ctrl

---
 rtl/lb_alloc_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/lb_alloc_ctrl.sv
// Load-buffer allocation controller: circular entry allocation, in-order retire,
// and memory-order violation recovery (replay request, then tail squash).
module lb_alloc_ctrl #(
  parameter int LB_DEPTH = 8,
  parameter int TAG_W    = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alloc_req,
  input  logic [TAG_W-1:0]            alloc_rob_tag,
  output logic                        alloc_gnt,
  output logic [$clog2(LB_DEPTH)-1:0] alloc_idx,
  input  logic                        commit_valid,
  input  logic [TAG_W-1:0]            commit_rob_tag,
  input  logic                        violation_detect,
  input  logic [$clog2(LB_DEPTH)-1:0] violation_idx,
  output logic                        flush_req,
  output logic [TAG_W-1:0]            flush_rob_tag,
  input  logic                        flush_ack,
  input  logic                        global_flush,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(LB_DEPTH):0]   count,
  output logic                        busy
);

  localparam int IW = $clog2(LB_DEPTH);

  typedef enum logic [1:0] {RUN = 2'd0, REQ = 2'd1, SQUASH = 2'd2} state_t;

  state_t              state;
  logic [IW:0]         head;
  logic [IW:0]         tail;
  logic [IW:0]         victim;
  logic [LB_DEPTH-1:0] valid;
  logic [TAG_W-1:0]    tags [LB_DEPTH];

  logic                retire;
  logic [IW:0]         head_nxt;
  logic [IW:0]         victim_age;
  logic [IW:0]         tail_age;
  logic [IW:0]         squash_tail;
  logic [IW:0]         span;
  logic [IW-1:0]       off;
  logic [LB_DEPTH-1:0] squash_clr;
  logic [LB_DEPTH-1:0] valid_nxt;

  assign full      = (head[IW-1:0] == tail[IW-1:0]) && (head[IW] != tail[IW]);
  assign empty     = (head == tail);
  assign count     = tail - head;
  assign alloc_idx = tail[IW-1:0];
  assign busy      = (state != RUN);
  assign flush_req = (state == REQ);
  assign alloc_gnt = rst_n & alloc_req & ~full & (state == RUN) & ~global_flush;

  // Ages are measured from the post-retire head so a victim that retired
  // (even in the squash cycle itself) falls back to tail = head.
  always_comb begin
    retire      = commit_valid & ~empty & valid[head[IW-1:0]]
                  & (tags[head[IW-1:0]] == commit_rob_tag) & ~global_flush;
    head_nxt    = head + {{IW{1'b0}}, retire};
    victim_age  = victim - head_nxt;
    tail_age    = tail - head_nxt;
    squash_tail = (victim_age > tail_age) ? head_nxt : victim;
    span        = tail - squash_tail;
    squash_clr  = '0;
    off         = '0;
    for (int i = 0; i < LB_DEPTH; i++) begin
      off           = IW'(i) - squash_tail[IW-1:0];
      squash_clr[i] = ({1'b0, off} < span);
    end
    valid_nxt = valid;
    if (state == SQUASH) valid_nxt = valid_nxt & ~squash_clr;
    if (retire) valid_nxt[head[IW-1:0]] = 1'b0;
    if (alloc_gnt) valid_nxt[tail[IW-1:0]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      head          <= '0;
      tail          <= '0;
      victim        <= '0;
      valid         <= '0;
      flush_rob_tag <= '0;
      for (int i = 0; i < LB_DEPTH; i++) tags[i] <= '0;
    end else if (global_flush) begin
      state <= RUN;
      head  <= '0;
      tail  <= '0;
      valid <= '0;
    end else begin
      valid <= valid_nxt;
      head  <= head_nxt;
      if (alloc_gnt) begin
        tags[tail[IW-1:0]] <= alloc_rob_tag;
        tail               <= tail + 1'b1;
      end
      case (state)
        RUN: begin
          if (violation_detect && valid[violation_idx]) begin
            state         <= REQ;
            flush_rob_tag <= tags[violation_idx];
            victim        <= {(violation_idx >= head[IW-1:0]) ? head[IW] : ~head[IW],
                              violation_idx};
          end
        end
        REQ: begin
          if (flush_ack) state <= SQUASH;
        end
        SQUASH: begin
          tail  <= squash_tail;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
